// File: rtl/reduce_engine.sv
// reduce_engine: per-tag reduction table feeding a pipelined multi-op ALU and a single output register
module reduce_engine #(
  parameter int FlitWidth = 82,
  parameter int PayloadWidth = 32,
  parameter int TableDepth = 8,
  parameter int ChildrenWidth = 4,
  parameter int AluLatency = 2,
  parameter logic [8:0] NodeId = 9'd0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [FlitWidth-1:0]         in_flit,
  input  logic [ChildrenWidth-1:0]     in_children,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [FlitWidth-1:0]         out_flit,
  output logic                         err_op,
  output logic                         err_ctx,
  output logic [$clog2(TableDepth):0]  occupancy
);
  localparam int IW = $clog2(TableDepth);
  localparam int OP_LO = 32;
  localparam int TAG_LO = 38;
  localparam int CTX_LO = 46;
  localparam int SRC_LO = 63;
  localparam logic [FlitWidth-1:0] VALID_BIT = FlitWidth'(1) << (FlitWidth - 1);
  localparam logic [FlitWidth-1:0] KEEP = ~(VALID_BIT | (FlitWidth'(9'h1FF) << SRC_LO));
  localparam logic [FlitWidth-1:0] SET = VALID_BIT | (FlitWidth'(NodeId) << SRC_LO);
  typedef enum logic [1:0] {IDLE, ACCUM, INFLIGHT, DONE} state_t;
  state_t                         st [TableDepth];
  state_t                         st_n [TableDepth];
  logic [FlitWidth-1:PayloadWidth] hdr [TableDepth];
  logic [PayloadWidth-1:0]        acc [TableDepth];
  logic [ChildrenWidth-1:0]       rem [TableDepth];
  logic [AluLatency-1:0]          pv;
  logic [IW-1:0]                  ps [AluLatency];
  logic [PayloadWidth-1:0]        pr [AluLatency];
  logic [IW-1:0]                  idx, sel;
  logic [3:0]                     op;
  logic [PayloadWidth-1:0]        pay, a, res;
  logic                           bad_op, ctx_bad, accept, alloc, issue, retire, any_done, load, pop;
  logic [IW-1:0]                  rs;
  assign idx = in_flit[TAG_LO +: IW];
  assign op = in_flit[OP_LO +: 4];
  assign pay = in_flit[PayloadWidth-1:0];
  assign a = acc[idx];
  assign in_ready = !(st[idx] == INFLIGHT || st[idx] == DONE);
  assign accept = in_valid && in_ready;
  assign bad_op = op > 4'd5;
  assign ctx_bad = st[idx] == ACCUM && hdr[idx][CTX_LO +: 8] != in_flit[CTX_LO +: 8];
  assign alloc = accept && !bad_op && st[idx] == IDLE;
  assign issue = accept && !bad_op && st[idx] == ACCUM && !ctx_bad;
  assign retire = pv[AluLatency-1];
  assign rs = ps[AluLatency-1];
  assign load = !out_valid || out_ready;
  assign pop = load && any_done;
  always_comb begin
    res = (op == 4'd0) ? a + pay :
          (op == 4'd1) ? (($signed(a) > $signed(pay)) ? a : pay) :
          (op == 4'd2) ? (($signed(a) < $signed(pay)) ? a : pay) :
          (op == 4'd3) ? a & pay :
          (op == 4'd4) ? a | pay : a ^ pay;
  end
  // Descending scan so the lowest-index DONE slot wins the output register.
  always_comb begin
    sel = '0;
    any_done = 1'b0;
    for (int i = TableDepth - 1; i >= 0; i--) begin
      if (st[i] == DONE) begin
        sel = IW'(i);
        any_done = 1'b1;
      end
    end
  end
  always_comb begin
    st_n = st;
    for (int i = 0; i < TableDepth; i++) begin
      if (alloc && idx == IW'(i)) st_n[i] = (in_children == '0) ? DONE : ACCUM;
      if (issue && idx == IW'(i)) st_n[i] = INFLIGHT;
      if (retire && rs == IW'(i)) st_n[i] = (rem[i] == ChildrenWidth'(1)) ? DONE : ACCUM;
      if (pop && sel == IW'(i)) st_n[i] = IDLE;
    end
  end
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < TableDepth; i++) occupancy = occupancy + (IW + 1)'(st[i] != IDLE);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TableDepth; i++) begin
        st[i] <= IDLE;
        hdr[i] <= '0;
        acc[i] <= '0;
        rem[i] <= '0;
      end
      for (int s = 0; s < AluLatency; s++) begin
        ps[s] <= '0;
        pr[s] <= '0;
      end
      pv <= '0;
      out_valid <= 1'b0;
      out_flit <= '0;
      err_op <= 1'b0;
      err_ctx <= 1'b0;
    end else begin
      st <= st_n;
      for (int i = 0; i < TableDepth; i++) begin
        if (alloc && idx == IW'(i)) begin
          hdr[i] <= in_flit[FlitWidth-1:PayloadWidth];
          acc[i] <= pay;
          rem[i] <= in_children;
        end
        if (retire && rs == IW'(i)) begin
          acc[i] <= pr[AluLatency-1];
          rem[i] <= rem[i] - ChildrenWidth'(1);
        end
      end
      pv[0] <= issue;
      ps[0] <= idx;
      pr[0] <= res;
      for (int s = 1; s < AluLatency; s++) begin
        pv[s] <= pv[s-1];
        ps[s] <= ps[s-1];
        pr[s] <= pr[s-1];
      end
      if (load) out_valid <= any_done;
      if (pop) out_flit <= ({hdr[sel], acc[sel]} & KEEP) | SET;
      err_op <= accept && bad_op;
      err_ctx <= accept && !bad_op && ctx_bad;
    end
  end
endmodule

// File: tb/tb_reduce_engine.sv
// tb_reduce_engine: table-driven reductions plus hand sequences for latency, backpressure, ctx, reset
module tb_reduce_engine;
  localparam logic [8:0] NODE = 9'h1A5;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [81:0] in_flit = '0;
  logic [3:0]  in_children = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [81:0] out_flit;
  logic        err_op, err_ctx;
  logic [3:0]  occupancy;
  int checks = 0;
  int errors = 0;
  reduce_engine #(.NodeId(NODE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
    .in_children(in_children), .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
    .err_op(err_op), .err_ctx(err_ctx), .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0]       op;
    logic [7:0]       tag;
    int               n;
    logic [2:0][31:0] p;
    logic [31:0]      res;
  } vec_t;
  vec_t tbl [8];
  function automatic logic [81:0] mk(input logic [3:0] op, input logic [7:0] tag, input logic [7:0] ctx, input logic [31:0] pay);
    logic [81:0] f;
    f = '0;
    f[31:0] = pay;
    f[35:32] = op;
    f[37:36] = 2'b10;
    f[45:38] = tag;
    f[53:46] = ctx;
    f[62:54] = 9'h155;
    f[71:63] = 9'h0F0;
    f[80:72] = 9'h0AB;
    f[81] = 1'b1;
    return f;
  endfunction
  function automatic logic [81:0] exp_flit(input logic [81:0] f, input logic [31:0] p);
    logic [81:0] r;
    r = f;
    r[81] = 1'b1;
    r[71:63] = NODE;
    r[31:0] = p;
    return r;
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic send(input logic [81:0] f, input logic [3:0] ch);
    in_flit = f;
    in_children = ch;
    in_valid = 1'b1;
    #1;
    for (int c = 0; c < 20 && !in_ready; c++) begin
      @(posedge clk);
      #2;
    end
    chk("in_ready_wait", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  task automatic wait_out();
    for (int c = 0; c < 30 && !out_valid; c++) begin
      @(posedge clk);
      #1;
    end
    chk("out_valid_wait", out_valid, 1);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  logic [81:0] f0, f1;
  initial begin
    tbl[0] = '{op: 4'd0, tag: 8'h23, n: 1, p: {32'd0, 32'd0, 32'd7}, res: 32'd7};
    tbl[1] = '{op: 4'd0, tag: 8'h01, n: 3, p: {32'hFFFFFFFD, 32'd10, 32'd5}, res: 32'd12};
    tbl[2] = '{op: 4'd1, tag: 8'h02, n: 3, p: {32'd2, 32'd9, 32'hFFFFFFFC}, res: 32'd9};
    tbl[3] = '{op: 4'd2, tag: 8'h45, n: 3, p: {32'd2, 32'd9, 32'hFFFFFFFC}, res: 32'hFFFFFFFC};
    tbl[4] = '{op: 4'd3, tag: 8'h06, n: 2, p: {32'd0, 32'h3C, 32'hF0}, res: 32'h30};
    tbl[5] = '{op: 4'd5, tag: 8'h07, n: 2, p: {32'd0, 32'h3C, 32'hF0}, res: 32'hCC};
    tbl[6] = '{op: 4'd4, tag: 8'h10, n: 2, p: {32'd0, 32'h0F, 32'hF0}, res: 32'hFF};
    tbl[7] = '{op: 4'd0, tag: 8'h04, n: 2, p: {32'd0, 32'd2, 32'hFFFFFFFF}, res: 32'd1};
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_flit", out_flit, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_err", {err_op, err_ctx}, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    for (int v = 0; v < 8; v++) begin
      f0 = mk(tbl[v].op, tbl[v].tag, 8'h5A, tbl[v].p[0]);
      send(f0, 4'(tbl[v].n - 1));
      for (int k = 1; k < tbl[v].n; k++) send(mk(tbl[v].op, tbl[v].tag, 8'h5A, tbl[v].p[k]), 4'd0);
      wait_out();
      chk($sformatf("vec%0d_flit", v), out_flit, exp_flit(f0, tbl[v].res));
      chk($sformatf("vec%0d_occ", v), occupancy, 0);
      cyc();
      chk($sformatf("vec%0d_drain", v), out_valid, 0);
    end
    f0 = mk(4'd0, 8'd3, 8'h01, 32'd7);
    send(f0, 4'd0);
    chk("leaf_e0_valid", out_valid, 0);
    chk("leaf_e0_occ", occupancy, 1);
    cyc();
    chk("leaf_e1_valid", out_valid, 1);
    chk("leaf_e1_flit", out_flit, exp_flit(f0, 32'd7));
    chk("leaf_e1_occ", occupancy, 0);
    f0 = mk(4'd0, 8'd1, 8'h02, 32'd5);
    send(f0, 4'd2);
    send(mk(4'd0, 8'd1, 8'h02, 32'd10), 4'd0);
    in_flit = mk(4'd0, 8'd1, 8'h02, 32'hFFFFFFFD);
    in_valid = 1'b1;
    #1;
    chk("sum_inflight_ready", in_ready, 0);
    send(mk(4'd0, 8'd1, 8'h02, 32'hFFFFFFFD), 4'd0);
    chk("sum_e0_valid", out_valid, 0);
    cyc();
    chk("sum_e1_valid", out_valid, 0);
    cyc();
    chk("sum_e2_valid", out_valid, 0);
    cyc();
    chk("sum_e3_valid", out_valid, 1);
    chk("sum_flit", out_flit, exp_flit(f0, 32'd12));
    cyc();
    send(mk(4'd7, 8'd5, 8'h03, 32'd9), 4'd0);
    chk("errop_pulse", err_op, 1);
    chk("errop_occ", occupancy, 0);
    cyc();
    chk("errop_clear", err_op, 0);
    for (int c = 0; c < 4; c++) begin
      chk("errop_no_out", out_valid, 0);
      cyc();
    end
    f0 = mk(4'd0, 8'd4, 8'h11, 32'd100);
    send(f0, 4'd2);
    send(mk(4'd0, 8'd4, 8'h22, 32'd5), 4'd0);
    chk("ctx_pulse", err_ctx, 1);
    chk("ctx_occ", occupancy, 1);
    cyc();
    chk("ctx_clear", err_ctx, 0);
    send(mk(4'd0, 8'd4, 8'h11, 32'd1), 4'd0);
    send(mk(4'd0, 8'd4, 8'h11, 32'd2), 4'd0);
    wait_out();
    chk("ctx_flit", out_flit, exp_flit(f0, 32'd103));
    cyc();
    out_ready = 1'b0;
    f0 = mk(4'd0, 8'd0, 8'h05, 32'h11);
    f1 = mk(4'd0, 8'd2, 8'h06, 32'h22);
    send(f0, 4'd0);
    send(f1, 4'd0);
    chk("bp_occ", occupancy, 1);
    for (int c = 0; c < 3; c++) begin
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_flit", out_flit, exp_flit(f0, 32'h11));
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_flit", out_flit, exp_flit(f1, 32'h22));
    cyc();
    chk("bp_empty", out_valid, 0);
    out_ready = 1'b0;
    send(mk(4'd0, 8'd6, 8'h07, 32'h66), 4'd0);
    send(mk(4'd0, 8'd1, 8'h08, 32'd50), 4'd1);
    send(mk(4'd0, 8'd1, 8'h08, 32'd7), 4'd0);
    chk("rstmid_pre_valid", out_valid, 1);
    chk("rstmid_pre_occ", occupancy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rstmid_valid", out_valid, 0);
    chk("rstmid_occ", occupancy, 0);
    chk("rstmid_flit", out_flit, 0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    cyc();
    for (int c = 0; c < 4; c++) begin
      chk("rstmid_no_out", out_valid, 0);
      cyc();
    end
    f0 = mk(4'd0, 8'd1, 8'h09, 32'd3);
    send(f0, 4'd1);
    send(mk(4'd0, 8'd1, 8'h09, 32'd4), 4'd0);
    wait_out();
    chk("post_rst_flit", out_flit, exp_flit(f0, 32'd7));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
